tape_io_dev: RTL and testbench
==============================

# tape_io_dev

Device-side model of the 5-bit character peripherals attached to the core's device ports: a tape reader that answers `dev_input_rdy` with `dev_input_val`/`dev_input_data`, and a tape punch that accepts `dev_output_data` on `dev_output_rdy` and answers with `dev_output_ack`. Host logic preloads reader characters and drains punched characters through two FIFO ports. The block instantiates beside `soc_top` in simulation and FPGA test harnesses. Programmable delays model mechanical character time.

## Interface
- `DEPTH`, 16, entries per FIFO; power of two, ≥2
- `CHAR_DELAY`, 4, reader cycles from pop to `dev_input_val`; ≥1
- `PUNCH_DELAY`, 4, punch cycles from capture to `dev_output_ack`; ≥1

- `clk` in 1 — single clock
- `reset` in 1 — synchronous, active-high
- `dev_input_rdy` in 1 — core requests a character (level)
- `dev_input_val` out 1 — character valid, one-cycle pulse
- `dev_input_data` out 5 — reader character (level, held until next)
- `dev_output_rdy` in 1 — core offers a character (level)
- `dev_output_data` in 5 — character offered by core
- `dev_output_ack` out 1 — character accepted, one-cycle pulse
- `host_wr_en` in 1 — push `host_wr_data` into reader FIFO
- `host_wr_data` in 5 — character to load
- `host_full` out 1 — reader FIFO full
- `host_rd_en` in 1 — pop punch FIFO
- `host_rd_data` out 5 — punch FIFO head (valid when `!host_empty`)
- `host_empty` out 1 — punch FIFO empty
- `rd_count` out $clog2(DEPTH)+1 — characters waiting in reader FIFO

## Operation
- Reader FSM: R_IDLE, R_FEED.
  - R_IDLE: if `dev_input_rdy` && reader FIFO non-empty → pop, register head into `dev_input_data`, load counter = CHAR_DELAY−1, go R_FEED.
  - R_FEED: decrement to 0. At 0 with `dev_input_rdy`=1 → `dev_input_val`=1 for one cycle, go R_IDLE. At 0 with rdy=0 → hold, pulse when rdy returns.
  - With rdy held high and FIFO non-empty, characters stream one per CHAR_DELAY+1 cycles.
  - Empty FIFO: stay R_IDLE, no val, data unchanged.
- Punch FSM: P_IDLE, P_BUSY, P_RELEASE.
  - P_IDLE: if `dev_output_rdy` && punch FIFO not full → push `dev_output_data`, load counter = PUNCH_DELAY−1, go P_BUSY. If FIFO full → stall in P_IDLE with no ack (backpressure).
  - P_BUSY: decrement to 0, then `dev_output_ack`=1 for one cycle, go P_RELEASE.
  - P_RELEASE: wait for `dev_output_rdy`=0 (≥1 cycle), then P_IDLE. Prevents a held rdy from being captured twice.
- FIFOs: writes to full and reads from empty are ignored, with no state change. Simultaneous push and pop on the same FIFO is legal and leaves the count unchanged (full: pop then push; empty: push only). Pointers wrap modulo DEPTH.
- `host_wr_en` and a reader pop in the same cycle are legal. `rd_count` reflects both.

## Timing
- Reset values: `dev_input_val`=0, `dev_input_data`=0, `dev_output_ack`=0, `host_full`=0, `host_empty`=1, `rd_count`=0. Both FSMs idle, counters 0.
- Reset mid-operation discards in-flight characters and both FIFO contents. No val or ack pulse is issued for them.
- Reader latency, rdy held: pop at cycle t, `dev_input_data` new from t+1, `dev_input_val` high in cycle t+CHAR_DELAY.
- Punch latency: capture at cycle t, `dev_output_ack` high in cycle t+PUNCH_DELAY. The character appears at `host_rd_data` and `host_empty` falls at t+1.
- All outputs are registered. There is no combinational path from any input to any output.
- `host_full`, `host_empty` and `rd_count` update the cycle after the push or pop.

## Structure
- Package `tape_io_pkg`: `CHAR_W`=5, reader state enum {R_IDLE, R_FEED}, punch state enum {P_IDLE, P_BUSY, P_RELEASE}.
- Sub-module `char_fifo` (parameter DEPTH; ports push/pop/data/full/empty/count) is instantiated twice, once as reader FIFO and once as punch FIFO.
- The top level holds the two FSMs and delay counters.

## Test plan
- Load 0x01, 0x1F, 0x0A; hold `dev_input_rdy`=1 with CHAR_DELAY=4 → three val pulses 5 cycles apart, data 0x01, 0x1F, 0x0A; `rd_count` 3→0.
- Reader FIFO empty with rdy=1 for 20 cycles → no val. Push 0x15 → val CHAR_DELAY cycles after the pop, data 0x15.
- Core offers 0x13 with rdy held 10 cycles, PUNCH_DELAY=4 → exactly one ack, 4 cycles after capture; `host_rd_data`=0x13; no second capture until rdy drops.
- Fill punch FIFO to DEPTH, offer another character → no ack, stall. Host pops one → capture proceeds and ack follows PUNCH_DELAY later.
- Drop rdy while reader in R_FEED → val is withheld and pulses in the first cycle rdy returns.
- Assert `reset` mid-R_FEED and mid-P_BUSY → no val or ack pulse; `host_empty`=1, `rd_count`=0, `dev_input_data`=0 on the next cycle.

Source files
------------

// File: rtl/tape_io_pkg.sv
// Shared character width and FSM state encodings for the tape reader/punch device model.
package tape_io_pkg;

    localparam int CHAR_W = 5;

    typedef enum logic {
        R_IDLE,
        R_FEED
    } reader_state_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_BUSY,
        P_RELEASE
    } punch_state_e;

endpackage

// File: rtl/char_fifo.sv
// Registered-output character FIFO used for both the reader preload queue and the punch output queue.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is still accepted when the same cycle pops, freeing the slot first.
    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((count_q != FULL_COUNT) || doPop);

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/tape_io_dev.sv
// Device-side tape reader and tape punch with host-facing FIFOs and mechanical character-time delays.
module tape_io_dev
    import tape_io_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int CHAR_DELAY  = 4,
    parameter int PUNCH_DELAY = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dev_input_rdy,
    output logic                   dev_input_val,
    output logic [CHAR_W-1:0]      dev_input_data,
    input  logic                   dev_output_rdy,
    input  logic [CHAR_W-1:0]      dev_output_data,
    output logic                   dev_output_ack,
    input  logic                   host_wr_en,
    input  logic [CHAR_W-1:0]      host_wr_data,
    output logic                   host_full,
    input  logic                   host_rd_en,
    output logic [CHAR_W-1:0]      host_rd_data,
    output logic                   host_empty,
    output logic [$clog2(DEPTH):0] rd_count
);

    localparam int RC_W = $clog2(CHAR_DELAY + 1);
    localparam int PC_W = $clog2(PUNCH_DELAY + 1);

    reader_state_e     readerState_q;
    reader_state_e     readerState_d;
    logic [RC_W-1:0]   readerCnt_q;
    logic [RC_W-1:0]   readerCnt_d;
    logic              val_q;
    logic              val_d;
    logic [CHAR_W-1:0] inData_q;
    logic [CHAR_W-1:0] inData_d;
    logic              readerPop;
    logic [CHAR_W-1:0] readerHead;
    logic              readerEmpty;

    punch_state_e      punchState_q;
    punch_state_e      punchState_d;
    logic [PC_W-1:0]   punchCnt_q;
    logic [PC_W-1:0]   punchCnt_d;
    logic              ack_q;
    logic              ack_d;
    logic              punchPush;
    logic              punchFull;

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W)
    ) u_reader_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (host_wr_en),
        .data_i  (host_wr_data),
        .pop_i   (readerPop),
        .data_o  (readerHead),
        .full_o  (host_full),
        .empty_o (readerEmpty),
        .count_o (rd_count)
    );

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W)
    ) u_punch_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (punchPush),
        .data_i  (dev_output_data),
        .pop_i   (host_rd_en),
        .data_o  (host_rd_data),
        .full_o  (punchFull),
        .empty_o (host_empty),
        .count_o ()
    );

    // val is registered, so it is decided one cycle ahead: when the counter is about to reach zero
    // (or already sits at zero waiting for rdy) and the core is requesting.
    always_comb begin
        readerState_d = readerState_q;
        readerCnt_d   = readerCnt_q;
        val_d         = 1'b0;
        inData_d      = inData_q;
        readerPop     = 1'b0;
        unique case (readerState_q)
            R_IDLE: begin
                if (dev_input_rdy && !readerEmpty) begin
                    readerPop     = 1'b1;
                    inData_d      = readerHead;
                    readerCnt_d   = RC_W'(CHAR_DELAY - 1);
                    val_d         = (CHAR_DELAY == 1);
                    readerState_d = R_FEED;
                end
            end
            R_FEED: begin
                if (val_q) begin
                    readerState_d = R_IDLE;
                end else begin
                    if (readerCnt_q != '0) begin
                        readerCnt_d = readerCnt_q - RC_W'(1);
                    end
                    if (dev_input_rdy && (readerCnt_q <= RC_W'(1))) begin
                        val_d = 1'b1;
                    end
                end
            end
            default: readerState_d = R_IDLE;
        endcase
    end

    always_comb begin
        punchState_d = punchState_q;
        punchCnt_d   = punchCnt_q;
        ack_d        = 1'b0;
        punchPush    = 1'b0;
        unique case (punchState_q)
            P_IDLE: begin
                if (dev_output_rdy && !punchFull) begin
                    punchPush    = 1'b1;
                    punchCnt_d   = PC_W'(PUNCH_DELAY - 1);
                    ack_d        = (PUNCH_DELAY == 1);
                    punchState_d = P_BUSY;
                end
            end
            P_BUSY: begin
                if (ack_q) begin
                    punchState_d = P_RELEASE;
                end else begin
                    if (punchCnt_q != '0) begin
                        punchCnt_d = punchCnt_q - PC_W'(1);
                    end
                    if (punchCnt_q <= PC_W'(1)) begin
                        ack_d = 1'b1;
                    end
                end
            end
            P_RELEASE: begin
                if (!dev_output_rdy) begin
                    punchState_d = P_IDLE;
                end
            end
            default: punchState_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readerState_q <= R_IDLE;
            readerCnt_q   <= '0;
            val_q         <= 1'b0;
            inData_q      <= '0;
            punchState_q  <= P_IDLE;
            punchCnt_q    <= '0;
            ack_q         <= 1'b0;
        end else begin
            readerState_q <= readerState_d;
            readerCnt_q   <= readerCnt_d;
            val_q         <= val_d;
            inData_q      <= inData_d;
            punchState_q  <= punchState_d;
            punchCnt_q    <= punchCnt_d;
            ack_q         <= ack_d;
        end
    end

    assign dev_input_val  = val_q;
    assign dev_input_data = inData_q;
    assign dev_output_ack = ack_q;

endmodule

// File: tb/tb_tape_io_dev.sv
// Directed self-checking bench for tape_io_dev: reader streaming, punch handshake, backpressure and reset.
module tb_tape_io_dev;
    import tape_io_pkg::*;

    localparam int DEPTH       = 16;
    localparam int CHAR_DELAY  = 4;
    localparam int PUNCH_DELAY = 4;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              dev_input_rdy;
    logic              dev_input_val;
    logic [CHAR_W-1:0] dev_input_data;
    logic              dev_output_rdy;
    logic [CHAR_W-1:0] dev_output_data;
    logic              dev_output_ack;
    logic              host_wr_en;
    logic [CHAR_W-1:0] host_wr_data;
    logic              host_full;
    logic              host_rd_en;
    logic [CHAR_W-1:0] host_rd_data;
    logic              host_empty;
    logic [CW-1:0]     rd_count;

    int compareCount  = 0;
    int mismatchCount = 0;
    int ackCount;

    tape_io_dev #(
        .DEPTH       (DEPTH),
        .CHAR_DELAY  (CHAR_DELAY),
        .PUNCH_DELAY (PUNCH_DELAY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dev_input_rdy   (dev_input_rdy),
        .dev_input_val   (dev_input_val),
        .dev_input_data  (dev_input_data),
        .dev_output_rdy  (dev_output_rdy),
        .dev_output_data (dev_output_data),
        .dev_output_ack  (dev_output_ack),
        .host_wr_en      (host_wr_en),
        .host_wr_data    (host_wr_data),
        .host_full       (host_full),
        .host_rd_en      (host_rd_en),
        .host_rd_data    (host_rd_data),
        .host_empty      (host_empty),
        .rd_count        (rd_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic punchOne(input logic [CHAR_W-1:0] ch);
        logic seen;
        seen            = 1'b0;
        dev_output_data = ch;
        dev_output_rdy  = 1'b1;
        for (int k = 0; k < 12 && !seen; k++) begin
            applyStimulus(1);
            if (dev_output_ack) seen = 1'b1;
        end
        checkOutput("punch_ack_seen", 8'(seen), 8'h01);
        dev_output_rdy = 1'b0;
        applyStimulus(2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset           = 1'b1;
        dev_input_rdy   = 1'b0;
        dev_output_rdy  = 1'b0;
        dev_output_data = '0;
        host_wr_en      = 1'b0;
        host_wr_data    = '0;
        host_rd_en      = 1'b0;
        applyStimulus(3);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("rst_val", 8'(dev_input_val), 8'h00);
        checkOutput("rst_data", 8'(dev_input_data), 8'h00);
        checkOutput("rst_ack", 8'(dev_output_ack), 8'h00);
        checkOutput("rst_full", 8'(host_full), 8'h00);
        checkOutput("rst_empty", 8'(host_empty), 8'h01);
        checkOutput("rst_count", 8'(rd_count), 8'h00);

        // Reader streaming: three characters, pop in cycle t, val at t+4, next pop at t+5.
        host_wr_en   = 1'b1;
        host_wr_data = 5'h01;
        applyStimulus(1);
        host_wr_data = 5'h1F;
        applyStimulus(1);
        host_wr_data = 5'h0A;
        applyStimulus(1);
        host_wr_en = 1'b0;
        checkOutput("load_count", 8'(rd_count), 8'h03);
        dev_input_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1);
            checkOutput("stream_val", 8'(dev_input_val), 8'((i == 4) || (i == 9) || (i == 14)));
            if (i == 1)  checkOutput("stream_count1", 8'(rd_count), 8'h02);
            if (i == 4)  checkOutput("stream_data0", 8'(dev_input_data), 8'h01);
            if (i == 9)  checkOutput("stream_data1", 8'(dev_input_data), 8'h1F);
            if (i == 14) checkOutput("stream_data2", 8'(dev_input_data), 8'h0A);
        end
        checkOutput("stream_count_end", 8'(rd_count), 8'h00);

        // Empty reader with rdy held: no val, data unchanged.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            checkOutput("empty_val", 8'(dev_input_val), 8'h00);
        end
        checkOutput("empty_data", 8'(dev_input_data), 8'h0A);

        host_wr_en   = 1'b1;
        host_wr_data = 5'h15;
        applyStimulus(1);
        host_wr_en = 1'b0;
        checkOutput("late_count", 8'(rd_count), 8'h01);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1);
            checkOutput("late_val", 8'(dev_input_val), 8'(i == 4));
            if (i == 4) checkOutput("late_data", 8'(dev_input_data), 8'h15);
        end

        // Drop rdy during R_FEED: val withheld until rdy is seen high again.
        dev_input_rdy = 1'b0;
        host_wr_en    = 1'b1;
        host_wr_data  = 5'h07;
        applyStimulus(1);
        host_wr_en    = 1'b0;
        dev_input_rdy = 1'b1;
        applyStimulus(1);
        dev_input_rdy = 1'b0;
        checkOutput("hold_data", 8'(dev_input_data), 8'h07);
        for (int i = 0; i < 8; i++) begin
            checkOutput("hold_val", 8'(dev_input_val), 8'h00);
            applyStimulus(1);
        end
        checkOutput("hold_val_last", 8'(dev_input_val), 8'h00);
        dev_input_rdy = 1'b1;
        applyStimulus(1);
        checkOutput("resume_val", 8'(dev_input_val), 8'h01);
        checkOutput("resume_data", 8'(dev_input_data), 8'h07);
        applyStimulus(1);
        checkOutput("resume_val_off", 8'(dev_input_val), 8'h00);
        dev_input_rdy = 1'b0;

        // Punch: rdy held 10 cycles gives exactly one capture and one ack 4 cycles later.
        dev_output_data = 5'h13;
        dev_output_rdy  = 1'b1;
        ackCount        = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1);
            checkOutput("punch_ack", 8'(dev_output_ack), 8'(i == 4));
            if (dev_output_ack) ackCount++;
            if (i == 1) begin
                checkOutput("punch_empty", 8'(host_empty), 8'h00);
                checkOutput("punch_data", 8'(host_rd_data), 8'h13);
            end
        end
        checkOutput("punch_ack_count", 8'(ackCount), 8'h01);
        dev_output_rdy = 1'b0;
        host_rd_en     = 1'b1;
        applyStimulus(1);
        host_rd_en = 1'b0;
        checkOutput("punch_single_capture", 8'(host_empty), 8'h01);

        // Fill the punch FIFO, then a further offer must stall until the host pops.
        for (int i = 0; i < DEPTH; i++) begin
            punchOne(5'(i + 3));
        end
        checkOutput("fill_empty", 8'(host_empty), 8'h00);
        dev_output_data = 5'h1E;
        dev_output_rdy  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("stall_ack", 8'(dev_output_ack), 8'h00);
        end
        checkOutput("stall_head", 8'(host_rd_data), 8'h03);
        host_rd_en = 1'b1;
        applyStimulus(1);
        host_rd_en = 1'b0;
        checkOutput("stall_head_next", 8'(host_rd_data), 8'h04);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1);
            checkOutput("unstall_ack", 8'(dev_output_ack), 8'(i == 4));
        end
        dev_output_rdy = 1'b0;
        applyStimulus(2);

        // Fill the reader FIFO; extra writes are ignored; push+pop while full keeps the count.
        host_wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            host_wr_data = 5'(i + 8);
            applyStimulus(1);
        end
        checkOutput("rfull_flag", 8'(host_full), 8'h01);
        checkOutput("rfull_count", 8'(rd_count), 8'h10);
        host_wr_data = 5'h1D;
        applyStimulus(1);
        host_wr_en = 1'b0;
        checkOutput("rfull_overflow_count", 8'(rd_count), 8'h10);

        // Start a reader character and a punch capture, then reset while both are in flight.
        host_rd_en = 1'b1;
        applyStimulus(1);
        host_rd_en      = 1'b0;
        dev_input_rdy   = 1'b1;
        host_wr_en      = 1'b1;
        host_wr_data    = 5'h1C;
        dev_output_rdy  = 1'b1;
        dev_output_data = 5'h09;
        applyStimulus(1);
        host_wr_en = 1'b0;
        checkOutput("pushpop_count", 8'(rd_count), 8'h10);
        checkOutput("pushpop_full", 8'(host_full), 8'h01);
        checkOutput("pushpop_data", 8'(dev_input_data), 8'h08);
        applyStimulus(1);
        reset          = 1'b1;
        dev_input_rdy  = 1'b0;
        dev_output_rdy = 1'b0;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("midrst_val", 8'(dev_input_val), 8'h00);
        checkOutput("midrst_ack", 8'(dev_output_ack), 8'h00);
        checkOutput("midrst_empty", 8'(host_empty), 8'h01);
        checkOutput("midrst_count", 8'(rd_count), 8'h00);
        checkOutput("midrst_data", 8'(dev_input_data), 8'h00);
        checkOutput("midrst_full", 8'(host_full), 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1);
            checkOutput("postrst_val", 8'(dev_input_val), 8'h00);
            checkOutput("postrst_ack", 8'(dev_output_ack), 8'h00);
        end
        checkOutput("postrst_empty", 8'(host_empty), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
